// File: rtl/cache_bus_pkg.sv
// ---------------------------------------------------------------------------
// cache_bus_pkg
//   Shared types and helpers for the cache bus arbiter slice.
//   - r_state_e : read-channel ownership FSM states
//   - w_state_e : writeback tracker FSM states
//   - default widths and line offset
//   - line_addr(): strips the byte-in-line offset from an address
// ---------------------------------------------------------------------------
package cache_bus_pkg;

  localparam int ADDR_W_DEFAULT   = 64;
  localparam int DATA_W_DEFAULT   = 64;
  localparam int LINE_OFF_DEFAULT = 4;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_IC   = 2'd1,
    R_DC   = 2'd2
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  // Addresses are carried as 64 bits here; the result keeps the line number
  // right-aligned so two lines compare equal exactly when they share a line.
  function automatic logic [63:0] line_addr(input logic [63:0] addr, input int off);
    return addr >> off;
  endfunction

endpackage

// File: rtl/cache_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// cache_bus_arbiter_if
//   Bundles the ICache, DCache and memory-side channels of the cache bus.
//   modport slave  : the arbiter's view (cache requests and memory responses in)
//   modport master : the environment's view (caches + memory model)
// ---------------------------------------------------------------------------
interface cache_bus_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);

  // ICache read channel
  logic              ic_r_valid;
  logic [ADDR_W-1:0] ic_r_raddr;
  logic [DATA_W-1:0] ic_r_rdata;
  logic              ic_r_rlast;
  logic              ic_r_ready;

  // DCache read channel
  logic              dc_r_valid;
  logic [ADDR_W-1:0] dc_r_raddr;
  logic [DATA_W-1:0] dc_r_rdata;
  logic              dc_r_rlast;
  logic              dc_r_ready;

  // DCache writeback and response
  logic              dc_w_valid;
  logic [ADDR_W-1:0] dc_w_waddr;
  logic [DATA_W-1:0] dc_w_wdata;
  logic              dc_w_wlast;
  logic              dc_w_ready;
  logic              dc_b_ready;
  logic              dc_b_valid;

  // Memory side
  logic              mem_r_valid;
  logic [ADDR_W-1:0] mem_r_raddr;
  logic [DATA_W-1:0] mem_r_rdata;
  logic              mem_r_rlast;
  logic              mem_r_ready;
  logic              mem_w_valid;
  logic [ADDR_W-1:0] mem_w_waddr;
  logic [DATA_W-1:0] mem_w_wdata;
  logic              mem_w_wlast;
  logic              mem_w_ready;
  logic              mem_b_valid;
  logic              mem_b_ready;

  modport slave (
    input  ic_r_valid, ic_r_raddr,
    input  dc_r_valid, dc_r_raddr,
    input  dc_w_valid, dc_w_waddr, dc_w_wdata, dc_w_wlast, dc_b_ready,
    input  mem_r_rdata, mem_r_rlast, mem_r_ready, mem_w_ready, mem_b_valid,
    output ic_r_rdata, ic_r_rlast, ic_r_ready,
    output dc_r_rdata, dc_r_rlast, dc_r_ready,
    output dc_w_ready, dc_b_valid,
    output mem_r_valid, mem_r_raddr,
    output mem_w_valid, mem_w_waddr, mem_w_wdata, mem_w_wlast, mem_b_ready
  );

  modport master (
    output ic_r_valid, ic_r_raddr,
    output dc_r_valid, dc_r_raddr,
    output dc_w_valid, dc_w_waddr, dc_w_wdata, dc_w_wlast, dc_b_ready,
    output mem_r_rdata, mem_r_rlast, mem_r_ready, mem_w_ready, mem_b_valid,
    input  ic_r_rdata, ic_r_rlast, ic_r_ready,
    input  dc_r_rdata, dc_r_rlast, dc_r_ready,
    input  dc_w_ready, dc_b_valid,
    input  mem_r_valid, mem_r_raddr,
    input  mem_w_valid, mem_w_waddr, mem_w_wdata, mem_w_wlast, mem_b_ready
  );

endinterface

// File: rtl/cache_bus_wr_tracker.sv
// ---------------------------------------------------------------------------
// cache_bus_wr_tracker
//   Follows the DCache writeback in flight (W_IDLE -> W_DATA -> W_RESP) and
//   remembers its line, so reads to that line can be held off until the
//   write response is accepted.
// Ports
//   clock, reset     : clock, synchronous active-high reset
//   i_w_valid        : writeback beat valid
//   i_w_waddr        : writeback line address
//   i_w_fire         : writeback beat accepted by memory
//   i_w_last         : last writeback beat
//   i_b_fire         : write response accepted by the DCache
//   i_cmp_addr[2]    : read addresses to test (0 = ICache, 1 = DCache)
//   o_hit[2]         : address hits the writeback line in flight
// ---------------------------------------------------------------------------
module cache_bus_wr_tracker
  import cache_bus_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEFAULT,
  parameter int LINE_OFF = LINE_OFF_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_w_valid,
  input  logic [ADDR_W-1:0] i_w_waddr,
  input  logic              i_w_fire,
  input  logic              i_w_last,
  input  logic              i_b_fire,
  input  logic [ADDR_W-1:0] i_cmp_addr [2],
  output logic [1:0]        o_hit
);

  w_state_e    r_state;
  w_state_e    w_state_next;
  logic [63:0] r_wline;
  logic [63:0] w_wline_next;
  logic [63:0] w_new_line;
  logic        w_busy;

  assign w_new_line = line_addr(64'(i_w_waddr), LINE_OFF);
  assign w_busy     = (r_state != W_IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= W_IDLE;
      r_wline <= '0;
    end else begin
      r_state <= w_state_next;
      r_wline <= w_wline_next;
    end
  end

  // A response arriving outside W_RESP is a protocol error; it is ignored.
  always_comb begin
    w_state_next = r_state;
    w_wline_next = r_wline;
    case (r_state)
      W_IDLE: begin
        if (i_w_valid) begin
          w_wline_next = w_new_line;
          w_state_next = (i_w_fire && i_w_last) ? W_RESP : W_DATA;
        end
      end
      W_DATA: begin
        if (i_w_fire && i_w_last) begin
          w_state_next = W_RESP;
        end
      end
      W_RESP: begin
        if (i_b_fire) begin
          w_state_next = W_IDLE;
        end
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  // While idle, the line currently being presented also counts, so a read
  // issued alongside the first writeback beat is already held off.
  for (genvar gi = 0; gi < 2; gi++) begin : g_cmp
    logic [63:0] w_line;
    assign w_line    = line_addr(64'(i_cmp_addr[gi]), LINE_OFF);
    assign o_hit[gi] = w_busy ? (w_line == r_wline)
                              : (i_w_valid && (w_line == w_new_line));
  end

endmodule

// File: rtl/cache_bus_arbiter.sv
// ---------------------------------------------------------------------------
// cache_bus_arbiter
//   Shares one memory-side cache bus between the ICache (reads) and the
//   DCache (reads + writebacks). The read channel is granted to one master
//   per burst and held until its rlast beat is accepted; the write/B
//   channels are a straight DCache passthrough.
// Ports
//   clock  : clock
//   reset  : synchronous, active-high reset
//   bus    : cache_bus_arbiter_if.slave (ICache, DCache and memory channels)
// Parameters
//   ADDR_W, DATA_W : address / beat widths
//   LINE_OFF       : log2(line bytes)
//   ARB_RR         : 1 = round-robin, 0 = DCache always wins a tie
// ---------------------------------------------------------------------------
module cache_bus_arbiter
  import cache_bus_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEFAULT,
  parameter int DATA_W   = DATA_W_DEFAULT,
  parameter int LINE_OFF = LINE_OFF_DEFAULT,
  parameter int ARB_RR   = 1
) (
  input logic                clock,
  input logic                reset,
  cache_bus_arbiter_if.slave bus
);

  localparam bit RR_EN = (ARB_RR != 0);

  r_state_e          r_state;
  r_state_e          w_state_next;
  logic              r_last_dc;       // 1 = DCache owned the last burst
  logic              w_last_dc_next;

  logic              w_mem_r_valid;
  logic [ADDR_W-1:0] w_mem_r_raddr;
  logic [DATA_W-1:0] w_rdata;
  logic              w_r_fire;
  logic              w_w_fire;
  logic              w_b_fire;
  logic [ADDR_W-1:0] w_cmp_addr [2];
  logic [1:0]        w_hit;
  logic              w_ic_elig;
  logic              w_dc_elig;

  // ---------------- write tracker / conflict check ----------------
  assign w_w_fire      = bus.dc_w_valid & bus.mem_w_ready;
  assign w_b_fire      = bus.mem_b_valid & bus.dc_b_ready;
  assign w_cmp_addr[0] = bus.ic_r_raddr;
  assign w_cmp_addr[1] = bus.dc_r_raddr;

  cache_bus_wr_tracker #(
    .ADDR_W   (ADDR_W),
    .LINE_OFF (LINE_OFF)
  ) u_wr_tracker (
    .clock      (clock),
    .reset      (reset),
    .i_w_valid  (bus.dc_w_valid),
    .i_w_waddr  (bus.dc_w_waddr),
    .i_w_fire   (w_w_fire),
    .i_w_last   (bus.dc_w_wlast),
    .i_b_fire   (w_b_fire),
    .i_cmp_addr (w_cmp_addr),
    .o_hit      (w_hit)
  );

  assign w_ic_elig = bus.ic_r_valid & ~w_hit[0];
  assign w_dc_elig = bus.dc_r_valid & ~w_hit[1];

  // ---------------- read FSM ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= R_IDLE;
      r_last_dc <= 1'b0;   // ICache counts as last, so DCache wins the first tie
    end else begin
      r_state   <= w_state_next;
      r_last_dc <= w_last_dc_next;
    end
  end

  // Grants are only decided in R_IDLE; the cycle after rlast is always idle.
  always_comb begin
    w_state_next   = r_state;
    w_last_dc_next = r_last_dc;
    case (r_state)
      R_IDLE: begin
        if (w_ic_elig && w_dc_elig) begin
          w_state_next = (RR_EN && r_last_dc) ? R_IC : R_DC;
        end else if (w_dc_elig) begin
          w_state_next = R_DC;
        end else if (w_ic_elig) begin
          w_state_next = R_IC;
        end
      end
      R_IC: begin
        if (w_r_fire && bus.mem_r_rlast) begin
          w_state_next   = R_IDLE;
          w_last_dc_next = 1'b0;
        end
      end
      R_DC: begin
        if (w_r_fire && bus.mem_r_rlast) begin
          w_state_next   = R_IDLE;
          w_last_dc_next = 1'b1;
        end
      end
      default: w_state_next = R_IDLE;
    endcase
  end

  // Request mux follows the owner's live valid; the burst itself only ends on rlast.
  always_comb begin
    w_mem_r_valid = 1'b0;
    w_mem_r_raddr = '0;
    case (r_state)
      R_IC: begin
        w_mem_r_valid = bus.ic_r_valid;
        w_mem_r_raddr = bus.ic_r_raddr;
      end
      R_DC: begin
        w_mem_r_valid = bus.dc_r_valid;
        w_mem_r_raddr = bus.dc_r_raddr;
      end
      default: begin
        w_mem_r_valid = 1'b0;
        w_mem_r_raddr = '0;
      end
    endcase
  end

  assign w_r_fire        = w_mem_r_valid & bus.mem_r_ready;
  assign bus.mem_r_valid = w_mem_r_valid;
  assign bus.mem_r_raddr = w_mem_r_raddr;

  // Read data is broadcast; only the owner's ready marks a beat as its own.
  assign w_rdata        = bus.mem_r_rdata;
  assign bus.ic_r_rdata = w_rdata;
  assign bus.dc_r_rdata = w_rdata;
  assign bus.ic_r_rlast = bus.mem_r_rlast;
  assign bus.dc_r_rlast = bus.mem_r_rlast;
  assign bus.ic_r_ready = bus.mem_r_ready & (r_state == R_IC);
  assign bus.dc_r_ready = bus.mem_r_ready & (r_state == R_DC);

  // ---------------- write / response passthrough ----------------
  assign bus.mem_w_valid = bus.dc_w_valid;
  assign bus.mem_w_waddr = bus.dc_w_waddr;
  assign bus.mem_w_wdata = bus.dc_w_wdata;
  assign bus.mem_w_wlast = bus.dc_w_wlast;
  assign bus.dc_w_ready  = bus.mem_w_ready;
  assign bus.dc_b_valid  = bus.mem_b_valid;
  assign bus.mem_b_ready = bus.dc_b_ready;

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_bus_arbiter
//   Two arbiters (index 0: round-robin, index 1: fixed DCache priority) see
//   identical stimulus. A behavioural model predicts every output each cycle;
//   directed literal checks pin the key grant/hold-off points.
// ---------------------------------------------------------------------------
module tb_cache_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // shared stimulus
  logic        s_reset = 1'b1;
  logic        s_ic_valid = 1'b0, s_dc_valid = 1'b0;
  logic [63:0] s_ic_addr = '0, s_dc_addr = '0;
  logic        s_dc_w_valid = 1'b0, s_dc_w_wlast = 1'b0, s_dc_b_ready = 1'b0;
  logic [63:0] s_dc_w_waddr = '0, s_dc_w_wdata = '0;
  logic        s_mem_r_ready = 1'b0, s_mem_r_rlast = 1'b0;
  logic [63:0] s_mem_r_rdata = '0;
  logic        s_mem_w_ready = 1'b0, s_mem_b_valid = 1'b0;

  // captured DUT outputs
  logic        o_ic_r_ready [2], o_dc_r_ready [2], o_ic_r_rlast [2], o_dc_r_rlast [2];
  logic [63:0] o_ic_r_rdata [2], o_dc_r_rdata [2];
  logic        o_mem_r_valid [2];
  logic [63:0] o_mem_r_raddr [2];
  logic        o_mem_w_valid [2], o_mem_w_wlast [2], o_dc_w_ready [2];
  logic [63:0] o_mem_w_waddr [2], o_mem_w_wdata [2];
  logic        o_dc_b_valid [2], o_mem_b_ready [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    cache_bus_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

    cache_bus_arbiter #(
      .ADDR_W   (64),
      .DATA_W   (64),
      .LINE_OFF (4),
      .ARB_RR   ((gi == 0) ? 1 : 0)
    ) dut (
      .clock (clk),
      .reset (s_reset),
      .bus   (bus)
    );

    assign bus.ic_r_valid  = s_ic_valid;
    assign bus.ic_r_raddr  = s_ic_addr;
    assign bus.dc_r_valid  = s_dc_valid;
    assign bus.dc_r_raddr  = s_dc_addr;
    assign bus.dc_w_valid  = s_dc_w_valid;
    assign bus.dc_w_waddr  = s_dc_w_waddr;
    assign bus.dc_w_wdata  = s_dc_w_wdata;
    assign bus.dc_w_wlast  = s_dc_w_wlast;
    assign bus.dc_b_ready  = s_dc_b_ready;
    assign bus.mem_r_rdata = s_mem_r_rdata;
    assign bus.mem_r_rlast = s_mem_r_rlast;
    assign bus.mem_r_ready = s_mem_r_ready;
    assign bus.mem_w_ready = s_mem_w_ready;
    assign bus.mem_b_valid = s_mem_b_valid;

    assign o_ic_r_ready[gi]  = bus.ic_r_ready;
    assign o_dc_r_ready[gi]  = bus.dc_r_ready;
    assign o_ic_r_rlast[gi]  = bus.ic_r_rlast;
    assign o_dc_r_rlast[gi]  = bus.dc_r_rlast;
    assign o_ic_r_rdata[gi]  = bus.ic_r_rdata;
    assign o_dc_r_rdata[gi]  = bus.dc_r_rdata;
    assign o_mem_r_valid[gi] = bus.mem_r_valid;
    assign o_mem_r_raddr[gi] = bus.mem_r_raddr;
    assign o_mem_w_valid[gi] = bus.mem_w_valid;
    assign o_mem_w_waddr[gi] = bus.mem_w_waddr;
    assign o_mem_w_wdata[gi] = bus.mem_w_wdata;
    assign o_mem_w_wlast[gi] = bus.mem_w_wlast;
    assign o_dc_w_ready[gi]  = bus.dc_w_ready;
    assign o_dc_b_valid[gi]  = bus.dc_b_valid;
    assign o_mem_b_ready[gi] = bus.mem_b_ready;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // owner: 0 none, 1 ICache, 2 DCache. last: who finished the previous burst.
  int          m_owner [2];
  int          m_last  [2];
  bit          m_wb_open;       // a writeback line is outstanding
  bit          m_wb_data_done;  // all its beats were accepted, waiting for B
  logic [63:0] m_wb_line;
  bit          started = 1'b0;

  function automatic bit conflict(logic [63:0] a);
    if (m_wb_open) return (a >> 4) == m_wb_line;
    return s_dc_w_valid && ((a >> 4) == (s_dc_w_waddr >> 4));
  endfunction

  task automatic compare_dut(int k);
    bit          ic_own, dc_own, exp_mrv;
    logic [63:0] exp_addr;
    string       p;
    p        = $sformatf("dut%0d.", k);
    ic_own   = (m_owner[k] == 1);
    dc_own   = (m_owner[k] == 2);
    exp_mrv  = ic_own ? s_ic_valid : (dc_own ? s_dc_valid : 1'b0);
    exp_addr = ic_own ? s_ic_addr : (dc_own ? s_dc_addr : 64'h0);
    chk({p, "mem_r_valid"}, 64'(o_mem_r_valid[k]), 64'(exp_mrv));
    chk({p, "mem_r_raddr"}, o_mem_r_raddr[k], exp_addr);
    chk({p, "ic_r_ready"},  64'(o_ic_r_ready[k]), 64'(s_mem_r_ready && ic_own));
    chk({p, "dc_r_ready"},  64'(o_dc_r_ready[k]), 64'(s_mem_r_ready && dc_own));
    chk({p, "ic_r_rdata"},  o_ic_r_rdata[k], s_mem_r_rdata);
    chk({p, "dc_r_rdata"},  o_dc_r_rdata[k], s_mem_r_rdata);
    chk({p, "ic_r_rlast"},  64'(o_ic_r_rlast[k]), 64'(s_mem_r_rlast));
    chk({p, "dc_r_rlast"},  64'(o_dc_r_rlast[k]), 64'(s_mem_r_rlast));
    chk({p, "mem_w_valid"}, 64'(o_mem_w_valid[k]), 64'(s_dc_w_valid));
    chk({p, "mem_w_waddr"}, o_mem_w_waddr[k], s_dc_w_waddr);
    chk({p, "mem_w_wdata"}, o_mem_w_wdata[k], s_dc_w_wdata);
    chk({p, "mem_w_wlast"}, 64'(o_mem_w_wlast[k]), 64'(s_dc_w_wlast));
    chk({p, "dc_w_ready"},  64'(o_dc_w_ready[k]), 64'(s_mem_w_ready));
    chk({p, "dc_b_valid"},  64'(o_dc_b_valid[k]), 64'(s_mem_b_valid));
    chk({p, "mem_b_ready"}, 64'(o_mem_b_ready[k]), 64'(s_dc_b_ready));
  endtask

  task automatic model_step();
    bit ie, de, rf, wf, bf;
    if (s_reset) begin
      for (int k = 0; k < 2; k++) begin
        m_owner[k] = 0;
        m_last[k]  = 1;
      end
      m_wb_open      = 1'b0;
      m_wb_data_done = 1'b0;
      started        = 1'b1;
      return;
    end
    for (int k = 0; k < 2; k++) begin
      if (m_owner[k] == 0) begin
        ie = s_ic_valid && !conflict(s_ic_addr);
        de = s_dc_valid && !conflict(s_dc_addr);
        if (ie && de)  m_owner[k] = (k == 0 && m_last[k] == 2) ? 1 : 2;
        else if (de)   m_owner[k] = 2;
        else if (ie)   m_owner[k] = 1;
      end else begin
        rf = s_mem_r_ready && ((m_owner[k] == 1) ? s_ic_valid : s_dc_valid);
        if (rf && s_mem_r_rlast) begin
          $display("[%0t] dut%0d read burst done for %s", $time, k,
                   (m_owner[k] == 1) ? "ICache" : "DCache");
          m_last[k]  = m_owner[k];
          m_owner[k] = 0;
        end
      end
    end
    wf = s_dc_w_valid && s_mem_w_ready;
    bf = s_mem_b_valid && s_dc_b_ready;
    if (!m_wb_open) begin
      if (s_dc_w_valid) begin
        m_wb_open      = 1'b1;
        m_wb_line      = s_dc_w_waddr >> 4;
        m_wb_data_done = wf && s_dc_w_wlast;
      end
    end else if (!m_wb_data_done) begin
      if (wf && s_dc_w_wlast) m_wb_data_done = 1'b1;
    end else if (bf) begin
      $display("[%0t] writeback line %h completed", $time, m_wb_line);
      m_wb_open = 1'b0;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (started && !s_reset) begin
        compare_dut(0);
        compare_dut(1);
        if (s_mem_b_valid && s_dc_b_ready)
          chk("b_fire_outside_resp", 64'(m_wb_open && m_wb_data_done), 64'd1);
      end
      model_step();
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic both(string nm, logic [63:0] a0, logic [63:0] a1, logic [63:0] e);
    chk({"dut0.", nm}, a0, e);
    chk({"dut1.", nm}, a1, e);
  endtask

  // Drives n beats on a granted burst; first beat also checks who got the grant.
  task automatic beats(int n, logic [63:0] e0, logic [63:0] e1);
    for (int b = 0; b < n; b++) begin
      s_mem_r_ready = 1'b1;
      s_mem_r_rdata = {$urandom, $urandom};
      s_mem_r_rlast = (b == n - 1);
      @(negedge clk);
      if (b == 0) begin
        chk("dut0.grant_raddr", o_mem_r_raddr[0], e0);
        chk("dut1.grant_raddr", o_mem_r_raddr[1], e1);
      end
      cyc(1);
    end
    s_mem_r_ready = 1'b0;
    s_mem_r_rlast = 1'b0;
  endtask

  // Called in an idle cycle with requests presented: no grant is visible yet.
  task automatic burst(int n, logic [63:0] e0, logic [63:0] e1);
    @(negedge clk);
    both("idle_mem_r_valid", 64'(o_mem_r_valid[0]), 64'(o_mem_r_valid[1]), 64'd0);
    cyc(1);
    beats(n, e0, e1);
  endtask

  localparam logic [63:0] A_IC = 64'h8000_1000;
  localparam logic [63:0] A_DC = 64'h8000_2000;

  initial begin
    cyc(3);
    s_reset = 1'b0;
    @(negedge clk);
    both("reset_mem_r_valid", 64'(o_mem_r_valid[0]), 64'(o_mem_r_valid[1]), 64'd0);
    both("reset_mem_r_raddr", o_mem_r_raddr[0], o_mem_r_raddr[1], 64'd0);
    cyc(1);

    // 1: ICache-only 2-beat read
    s_ic_valid = 1'b1; s_ic_addr = 64'h8000_0010;
    @(negedge clk);
    both("t1_req_cycle_valid", 64'(o_mem_r_valid[0]), 64'(o_mem_r_valid[1]), 64'd0);
    cyc(1);
    s_mem_r_ready = 1'b1; s_mem_r_rdata = 64'h1111; s_mem_r_rlast = 1'b0;
    @(negedge clk);
    both("t1_mem_r_valid", 64'(o_mem_r_valid[0]), 64'(o_mem_r_valid[1]), 64'd1);
    both("t1_mem_r_raddr", o_mem_r_raddr[0], o_mem_r_raddr[1], 64'h8000_0010);
    both("t1_ic_r_ready", 64'(o_ic_r_ready[0]), 64'(o_ic_r_ready[1]), 64'd1);
    both("t1_dc_r_ready", 64'(o_dc_r_ready[0]), 64'(o_dc_r_ready[1]), 64'd0);
    cyc(1);
    s_mem_r_rdata = 64'h2222; s_mem_r_rlast = 1'b1;
    @(negedge clk);
    both("t1_beat2_ready", 64'(o_ic_r_ready[0]), 64'(o_ic_r_ready[1]), 64'd1);
    both("t1_beat2_rdata", o_ic_r_rdata[0], o_ic_r_rdata[1], 64'h2222);
    cyc(1);
    s_mem_r_ready = 1'b0; s_mem_r_rlast = 1'b0; s_ic_valid = 1'b0;

    // 2+3: both request continuously after reset
    s_reset = 1'b1;
    cyc(1);
    s_reset = 1'b0;
    s_ic_valid = 1'b1; s_ic_addr = A_IC;
    s_dc_valid = 1'b1; s_dc_addr = A_DC;
    burst(2, A_DC, A_DC);
    burst(2, A_IC, A_DC);
    burst(2, A_DC, A_DC);
    burst(2, A_IC, A_DC);
    s_dc_valid = 1'b0;
    burst(2, A_IC, A_IC);
    s_ic_valid = 1'b0;

    // 4: writeback to line 0x8000_0100 holds off an ICache read of the same line
    s_dc_w_valid = 1'b1; s_dc_w_waddr = 64'h8000_0100; s_dc_w_wdata = 64'hAAAA;
    s_dc_w_wlast = 1'b0; s_mem_w_ready = 1'b1; s_dc_b_ready = 1'b1;
    s_ic_valid = 1'b1; s_ic_addr = 64'h8000_0108;
    @(negedge clk);
    both("t4_mem_w_valid", 64'(o_mem_w_valid[0]), 64'(o_mem_w_valid[1]), 64'd1);
    both("t4_mem_w_waddr", o_mem_w_waddr[0], o_mem_w_waddr[1], 64'h8000_0100);
    cyc(1);
    s_dc_w_wdata = 64'hBBBB; s_dc_w_wlast = 1'b1;
    @(negedge clk);
    both("t4_held_beat2", 64'(o_mem_r_valid[0]), 64'(o_mem_r_valid[1]), 64'd0);
    cyc(1);
    s_dc_w_valid = 1'b0; s_dc_w_wlast = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      both("t4_held_wait_b", 64'(o_mem_r_valid[0]), 64'(o_mem_r_valid[1]), 64'd0);
      cyc(1);
    end
    s_mem_b_valid = 1'b1;
    @(negedge clk);
    both("t4_dc_b_valid", 64'(o_dc_b_valid[0]), 64'(o_dc_b_valid[1]), 64'd1);
    both("t4_held_bfire", 64'(o_mem_r_valid[0]), 64'(o_mem_r_valid[1]), 64'd0);
    cyc(1);
    s_mem_b_valid = 1'b0;
    @(negedge clk);
    both("t4_decide_cycle", 64'(o_mem_r_valid[0]), 64'(o_mem_r_valid[1]), 64'd0);
    cyc(1);
    @(negedge clk);
    both("t4_granted", 64'(o_mem_r_valid[0]), 64'(o_mem_r_valid[1]), 64'd1);
    cyc(1);
    beats(2, 64'h8000_0108, 64'h8000_0108);

    // 4b: other line during a writeback is granted at once
    s_dc_w_valid = 1'b1; s_dc_w_waddr = 64'h8000_0100; s_dc_w_wdata = 64'hCCCC;
    s_dc_w_wlast = 1'b1;
    s_ic_addr = 64'h8000_0200;
    cyc(1);
    s_dc_w_valid = 1'b0; s_dc_w_wlast = 1'b0;
    @(negedge clk);
    both("t4b_granted", 64'(o_mem_r_valid[0]), 64'(o_mem_r_valid[1]), 64'd1);
    both("t4b_raddr", o_mem_r_raddr[0], o_mem_r_raddr[1], 64'h8000_0200);
    cyc(1);
    beats(2, 64'h8000_0200, 64'h8000_0200);
    s_ic_valid = 1'b0;
    s_mem_b_valid = 1'b1;
    cyc(1);
    s_mem_b_valid = 1'b0;

    // 5: DCache read and writeback in the same cycle, different lines
    s_dc_valid = 1'b1; s_dc_addr = 64'h8000_0300;
    s_dc_w_valid = 1'b1; s_dc_w_waddr = 64'h8000_0400; s_dc_w_wdata = 64'hDDDD;
    s_dc_w_wlast = 1'b0;
    @(negedge clk);
    both("t5_w_first", 64'(o_mem_w_valid[0]), 64'(o_mem_w_valid[1]), 64'd1);
    cyc(1);
    s_dc_w_wdata = 64'hEEEE; s_dc_w_wlast = 1'b1;
    @(negedge clk);
    both("t5_r_granted", 64'(o_mem_r_valid[0]), 64'(o_mem_r_valid[1]), 64'd1);
    both("t5_w_concurrent", 64'(o_mem_w_valid[0]), 64'(o_mem_w_valid[1]), 64'd1);
    cyc(1);
    s_dc_w_valid = 1'b0; s_dc_w_wlast = 1'b0;
    beats(2, 64'h8000_0300, 64'h8000_0300);
    s_dc_valid = 1'b0;
    s_mem_b_valid = 1'b1;
    cyc(1);
    s_mem_b_valid = 1'b0;

    // 6: reset on the first beat of an ICache burst
    s_ic_valid = 1'b1; s_ic_addr = 64'h8000_0500;
    cyc(1);
    s_mem_r_ready = 1'b1; s_mem_r_rdata = 64'h5555; s_mem_r_rlast = 1'b0;
    s_reset = 1'b1;
    @(negedge clk);
    both("t6_beat1_ready", 64'(o_ic_r_ready[0]), 64'(o_ic_r_ready[1]), 64'd1);
    cyc(1);
    s_reset = 1'b0; s_ic_valid = 1'b0;
    @(negedge clk);
    both("t6_after_rst_valid", 64'(o_mem_r_valid[0]), 64'(o_mem_r_valid[1]), 64'd0);
    both("t6_after_rst_icrdy", 64'(o_ic_r_ready[0]), 64'(o_ic_r_ready[1]), 64'd0);
    both("t6_after_rst_dcrdy", 64'(o_dc_r_ready[0]), 64'(o_dc_r_ready[1]), 64'd0);
    cyc(1);
    s_mem_r_ready = 1'b0;
    s_dc_valid = 1'b1; s_dc_addr = 64'h8000_0600;
    burst(2, 64'h8000_0600, 64'h8000_0600);
    s_dc_valid = 1'b0;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation still running at %0t, limit 100000", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
